cby_param_cfg_shadow: RTL and testbench
=======================================

// Module: cby_param_cfg_shadow
// PURPOSE
//  Parametrised Y-direction connection block with a built-in configuration controller.
//  - Passes CHAN_W vertical tracks straight through in both directions.
//  - Drives NUM_IPIN grid input pins. Each pin comes from a MUX_SIZE-input tap mux.
//  - Mux selects are loaded serially on the ccff chain into a shift register.
//  - Selects reach the muxes only on a validated commit into a shadow register,
//    so the routing never glitches while bits are shifting.
// PARAMETERS
//  CHAN_W     25  tracks per direction
//  NUM_IPIN   4   grid input pins driven by this block
//  MUX_SIZE   10  inputs per pin mux; even, <= 2*CHAN_W
//  TAP_STRIDE 6   track spacing between successive tap pairs
//  SEL_W      4   binary select width per pin; 2**SEL_W >= MUX_SIZE
//  CFG_LEN    NUM_IPIN*SEL_W  config bits (derived localparam, not overridable)
// PORTS
//  prog_clk         in  1         configuration clock, the only clock
//  pReset           in  1         synchronous active-high reset
//  chany_bottom_in  in  CHAN_W    tracks entering from below
//  chany_top_in     in  CHAN_W    tracks entering from above
//  ccff_head        in  1         serial config data in
//  ccff_en          in  1         shift one config bit this cycle
//  ccff_commit      in  1         request copy of shift reg to active selects
//  chany_bottom_out out CHAN_W    = chany_top_in (combinational)
//  chany_top_out    out CHAN_W    = chany_bottom_in (combinational)
//  ipin_out         out NUM_IPIN  mux outputs to the right grid
//  ccff_tail        out 1         sr[CFG_LEN-1], registered serial out
//  cfg_done         out 1         last commit succeeded
//  cfg_err          out 1         sticky: commit attempted with count != CFG_LEN
// BEHAVIOUR
//  Registers: sr[CFG_LEN], act[CFG_LEN], cnt, state, cfg_done, cfg_err.
//  Reset (pReset=1 at a prog_clk edge) clears every register to 0 and sets state=IDLE.
//   - Post-reset outputs: ccff_tail=0, cfg_done=0, cfg_err=0, and every ipin selects input 0.
//  Shift (ccff_en=1, ccff_commit=0):
//   - sr <= {sr[CFG_LEN-2:0], ccff_head}.
//   - cnt increments and saturates at CFG_LEN+1.
//   - cfg_done <= 0.
//  Select mapping: act[i*SEL_W +: SEL_W] is pin i's select.
//   - The last bit shifted before a commit lands at act[0].
//   - So bits are shifted pin NUM_IPIN-1 first, each select MSB first.
//  State machine, one cycle per transition:
//   - IDLE (cnt=0), LOAD (0<cnt<CFG_LEN), FULL (cnt=CFG_LEN), OVER (cnt>CFG_LEN).
//   - A shift advances IDLE->LOAD->FULL->OVER; OVER holds on further shifts.
//  Commit (ccff_commit=1):
//   - Has priority over ccff_en; any shift in the same cycle is dropped.
//   - In FULL: act <= sr, cfg_done <= 1, cfg_err <= 0, cnt <= 0, state <= IDLE.
//   - In any other state: act unchanged, cfg_err <= 1, cnt <= 0, state <= IDLE, sr kept.
//  Latency: the new routing is visible on ipin_out in the cycle after the commit edge.
//  Mux tap for pin i, input j:
//   - Track t = (i + (j>>1)*TAP_STRIDE) mod CHAN_W.
//   - Even j uses chany_bottom_in[t]; odd j uses chany_top_in[t].
//  Select >= MUX_SIZE drives ipin_out[i] = 0.
//  ipin_out and pass-throughs are combinational from act and the inputs.
//  Reset mid-load discards the partial bits; act returns to 0.
// TESTING
//  T1 Reset: pReset=1 for 2 cycles -> all outputs 0; ipin_out[0]=chany_bottom_in[0];
//     ipin_out[1]=bottom_in[1].
//  T2 Good load: shift 16 bits, 12 zeros then 0,0,1,1, then commit -> cfg_done=1;
//     ipin_out[0]=chany_top_in[6]; other pins follow bottom_in[i].
//  T3 Short load: 15 shifts then commit -> cfg_err=1, cfg_done=0, act unchanged.
//     Then 16 shifts plus commit -> cfg_err=0, cfg_done=1.
//  T4 Overflow: 17 shifts then commit -> cfg_err=1.
//     Also, 16 shifts then commit with ccff_en=1 in the same cycle -> commit succeeds,
//     and the extra bit is not shifted.
//  T5 Out of range: load pin 3 select = 4'hC -> ipin_out[3]=0 for any track values.
//     Pass-throughs stay equal for random inputs.
//  T6 Chain and mid-load reset: ccff_tail reproduces ccff_head delayed 16 shifts.
//     pReset after 8 shifts -> cnt=0, sr=0, act=0; a fresh 16-bit load then commits cleanly.

Source files
------------

// File: rtl/cby_param_cfg_shadow.sv
// Y-direction connection block: straight-through vertical tracks plus per-pin tap muxes
// whose selects are shifted in serially and only take effect on a validated commit.
module cby_param_cfg_shadow #(
   parameter int CHAN_W     = 25,
   parameter int NUM_IPIN   = 4,
   parameter int MUX_SIZE   = 10,
   parameter int TAP_STRIDE = 6,
   parameter int SEL_W      = 4
) (
   input  logic                prog_clk,
   input  logic                pReset,
   input  logic [CHAN_W-1:0]   chany_bottom_in,
   input  logic [CHAN_W-1:0]   chany_top_in,
   input  logic                ccff_head,
   input  logic                ccff_en,
   input  logic                ccff_commit,
   output logic [CHAN_W-1:0]   chany_bottom_out,
   output logic [CHAN_W-1:0]   chany_top_out,
   output logic [NUM_IPIN-1:0] ipin_out,
   output logic                ccff_tail,
   output logic                cfg_done,
   output logic                cfg_err
);

   localparam int CFG_LEN  = NUM_IPIN * SEL_W;
   localparam int CNT_W    = $clog2(CFG_LEN + 2);
   localparam int TAP_SLOT = 2 ** SEL_W;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      FULL,
      OVER
   } state_t;

   state_t                                r_state;
   logic [CFG_LEN-1:0]                    r_sr;
   logic [CFG_LEN-1:0]                    r_act;
   logic [CNT_W-1:0]                      r_cnt;
   logic                                  r_done;
   logic                                  r_err;
   logic [NUM_IPIN-1:0][TAP_SLOT-1:0]     w_tap;

   // Commit beats shift; only a commit from FULL may touch the active selects.
   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         r_state <= IDLE;
         r_sr    <= '0;
         r_act   <= '0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else if (ccff_commit) begin
         r_cnt   <= '0;
         r_state <= IDLE;
         if (r_state == FULL) begin
            r_act  <= r_sr;
            r_done <= 1'b1;
            r_err  <= 1'b0;
         end else begin
            r_done <= 1'b0;
            r_err  <= 1'b1;
         end
      end else if (ccff_en) begin
         r_sr   <= {r_sr[CFG_LEN-2:0], ccff_head};
         r_done <= 1'b0;
         if (r_cnt < CNT_W'(CFG_LEN + 1)) begin
            r_cnt <= r_cnt + 1'b1;
         end
         case (r_state)
            IDLE:    r_state <= LOAD;
            LOAD:    r_state <= (r_cnt == CNT_W'(CFG_LEN - 1)) ? FULL : LOAD;
            FULL:    r_state <= OVER;
            default: r_state <= OVER;
         endcase
      end
   end

   // Tap slots past MUX_SIZE are tied low so out-of-range selects output 0.
   for (genvar gi = 0; gi < NUM_IPIN; gi++) begin : g_pin
      for (genvar gj = 0; gj < TAP_SLOT; gj++) begin : g_tap
         if (gj >= MUX_SIZE) begin : g_zero
            assign w_tap[gi][gj] = 1'b0;
         end else if ((gj % 2) == 0) begin : g_bot
            assign w_tap[gi][gj] = chany_bottom_in[(gi + (gj / 2) * TAP_STRIDE) % CHAN_W];
         end else begin : g_top
            assign w_tap[gi][gj] = chany_top_in[(gi + (gj / 2) * TAP_STRIDE) % CHAN_W];
         end
      end
      assign ipin_out[gi] = w_tap[gi][r_act[gi*SEL_W +: SEL_W]];
   end

   assign chany_bottom_out = chany_top_in;
   assign chany_top_out    = chany_bottom_in;
   assign ccff_tail        = r_sr[CFG_LEN-1];
   assign cfg_done         = r_done;
   assign cfg_err          = r_err;

endmodule

// File: tb/tb_cby_param_cfg_shadow.sv
// Randomised bench for cby_param_cfg_shadow: a high-level model predicts every cycle's
// outputs into a queue, and a negedge monitor pops and compares them.
module tb_cby_param_cfg_shadow;

   localparam int CHAN_W     = 25;
   localparam int NUM_IPIN   = 4;
   localparam int MUX_SIZE   = 10;
   localparam int TAP_STRIDE = 6;
   localparam int SEL_W      = 4;
   localparam int CFG_LEN    = NUM_IPIN * SEL_W;

   logic                prog_clk = 1'b0;
   logic                pReset;
   logic [CHAN_W-1:0]   chany_bottom_in;
   logic [CHAN_W-1:0]   chany_top_in;
   logic                ccff_head;
   logic                ccff_en;
   logic                ccff_commit;
   logic [CHAN_W-1:0]   chany_bottom_out;
   logic [CHAN_W-1:0]   chany_top_out;
   logic [NUM_IPIN-1:0] ipin_out;
   logic                ccff_tail;
   logic                cfg_done;
   logic                cfg_err;

   cby_param_cfg_shadow #(
      .CHAN_W(CHAN_W), .NUM_IPIN(NUM_IPIN), .MUX_SIZE(MUX_SIZE),
      .TAP_STRIDE(TAP_STRIDE), .SEL_W(SEL_W)
   ) dut (
      .prog_clk(prog_clk), .pReset(pReset),
      .chany_bottom_in(chany_bottom_in), .chany_top_in(chany_top_in),
      .ccff_head(ccff_head), .ccff_en(ccff_en), .ccff_commit(ccff_commit),
      .chany_bottom_out(chany_bottom_out), .chany_top_out(chany_top_out),
      .ipin_out(ipin_out), .ccff_tail(ccff_tail),
      .cfg_done(cfg_done), .cfg_err(cfg_err)
   );

   always #5 prog_clk = ~prog_clk;

   typedef struct {
      logic [NUM_IPIN-1:0] ipin;
      logic [CHAN_W-1:0]   botOut;
      logic [CHAN_W-1:0]   topOut;
      logic                tail;
      logic                done;
      logic                err;
      string               tag;
   } expT;

   expT expQ[$];
   expT monE;
   int  checks = 0;
   int  errors = 0;
   string curTag = "init";

   // Reference model: last CFG_LEN shifted bits (oldest first), bit count, decoded selects.
   bit  mSr[$];
   int  mCnt;
   int  mSel[NUM_IPIN];
   bit  mDone;
   bit  mErr;

   function automatic void modelReset();
      mSr.delete();
      for (int k = 0; k < CFG_LEN; k++) mSr.push_back(1'b0);
      mCnt  = 0;
      mDone = 1'b0;
      mErr  = 1'b0;
      for (int p = 0; p < NUM_IPIN; p++) mSel[p] = 0;
   endfunction

   function automatic logic [NUM_IPIN-1:0] modelIpin(logic [CHAN_W-1:0] bot, logic [CHAN_W-1:0] top);
      logic [NUM_IPIN-1:0] r;
      r = '0;
      for (int p = 0; p < NUM_IPIN; p++) begin
         if (mSel[p] < MUX_SIZE) begin
            int t;
            t = (p + (mSel[p] / 2) * TAP_STRIDE) % CHAN_W;
            r[p] = (mSel[p] % 2 == 0) ? bot[t] : top[t];
         end
      end
      return r;
   endfunction

   function automatic void modelClock(bit rst, bit en, bit head, bit commit);
      if (rst) begin
         modelReset();
      end else if (commit) begin
         if (mCnt == CFG_LEN) begin
            // Most recently shifted bit is act[0]
            for (int p = 0; p < NUM_IPIN; p++) begin
               mSel[p] = 0;
               for (int b = 0; b < SEL_W; b++)
                  if (mSr[CFG_LEN-1-(p*SEL_W+b)]) mSel[p] += (1 << b);
            end
            mDone = 1'b1;
            mErr  = 1'b0;
         end else begin
            mDone = 1'b0;
            mErr  = 1'b1;
         end
         mCnt = 0;
      end else if (en) begin
         mSr.push_back(head);
         void'(mSr.pop_front());
         if (mCnt < CFG_LEN + 1) mCnt++;
         mDone = 1'b0;
      end
   endfunction

   task automatic applyStimulus(input bit rst, input bit en, input bit head, input bit commit);
      expT e;
      pReset          = rst;
      ccff_en         = en;
      ccff_head       = head;
      ccff_commit     = commit;
      chany_bottom_in = CHAN_W'($urandom);
      chany_top_in    = CHAN_W'($urandom);
      e.ipin   = modelIpin(chany_bottom_in, chany_top_in);
      e.botOut = chany_top_in;
      e.topOut = chany_bottom_in;
      e.tail   = mSr[0];
      e.done   = mDone;
      e.err    = mErr;
      e.tag    = curTag;
      expQ.push_back(e);
      @(posedge prog_clk);
      modelClock(rst, en, head, commit);
      #1;
   endtask

   task automatic shiftBits(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
   endtask

   task automatic loadSelects(input int sel[NUM_IPIN], input bit enOnCommit);
      for (int p = NUM_IPIN - 1; p >= 0; p--)
         for (int b = SEL_W - 1; b >= 0; b--)
            applyStimulus(1'b0, 1'b1, 1'((sel[p] >> b) & 1), 1'b0);
      applyStimulus(1'b0, enOnCommit, 1'($urandom_range(0, 1)), 1'b1);
   endtask

   function automatic void cmp(string name, logic [CHAN_W-1:0] actual, logic [CHAN_W-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s (%s): got %h expected %h at %0t", name, monE.tag, actual, expected, $time);
      end
   endfunction

   task automatic checkOutput();
      cmp("ipin_out", CHAN_W'(ipin_out), CHAN_W'(monE.ipin));
      cmp("chany_bottom_out", chany_bottom_out, monE.botOut);
      cmp("chany_top_out", chany_top_out, monE.topOut);
      cmp("ccff_tail", CHAN_W'(ccff_tail), CHAN_W'(monE.tail));
      cmp("cfg_done", CHAN_W'(cfg_done), CHAN_W'(monE.done));
      cmp("cfg_err", CHAN_W'(cfg_err), CHAN_W'(monE.err));
   endtask

   // Monitor: one expected record per cycle, compared mid-cycle
   always @(negedge prog_clk) begin
      if (expQ.size() > 0) begin
         monE = expQ.pop_front();
         checkOutput();
      end
   end

   initial begin
      int sel[NUM_IPIN];
      pReset = 1'b1; ccff_en = 1'b0; ccff_head = 1'b0; ccff_commit = 1'b0;
      chany_bottom_in = '0; chany_top_in = '0;
      @(posedge prog_clk); #1;
      modelReset();

      curTag = "T1 reset";
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

      curTag = "T2 good load";
      sel = '{3, 0, 0, 0};
      loadSelects(sel, 1'b0);
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

      curTag = "T3 short load";
      shiftBits(15);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      sel = '{1, 7, 9, 4};
      loadSelects(sel, 1'b0);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

      curTag = "T4 overflow";
      shiftBits(17);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      sel = '{8, 5, 2, 6};
      loadSelects(sel, 1'b1);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

      curTag = "T5 out of range";
      sel = '{0, 1, 2, 12};
      loadSelects(sel, 1'b0);
      repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

      curTag = "T6 chain";
      shiftBits(40);
      curTag = "T6 mid-load reset";
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      shiftBits(8);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      sel = '{9, 3, 6, 1};
      loadSelects(sel, 1'b0);
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

      curTag = "random";
      repeat (60) begin
         case ($urandom_range(0, 4))
            0, 1: begin
               for (int p = 0; p < NUM_IPIN; p++) sel[p] = $urandom_range(0, 15);
               loadSelects(sel, 1'($urandom_range(0, 1)));
            end
            2: begin
               shiftBits($urandom_range(1, 20));
               applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
            end
            3: repeat ($urandom_range(1, 4)) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            default: applyStimulus(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                                   1'($urandom_range(0, 1)), 1'b0);
         endcase
      end

      repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 10 && expQ.size() > 0; k++) @(posedge prog_clk);
      if (expQ.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain: %0d records left, expected 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
